// File: rtl/matmul_seq_if.sv
// Control and RAM-port bundle for matmul_seq: start/dim handshake, A/B read ports, C write port.
interface matmul_seq_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  logic          start;
  logic [5:0]    dim_m1;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;

  modport master (
    input  start, dim_m1, a_data, b_data,
    output busy, done, rd_en, a_addr, b_addr, c_we, c_addr, c_data
  );

  modport slave (
    output start, dim_m1, a_data, b_data,
    input  busy, done, rd_en, a_addr, b_addr, c_we, c_addr, c_data
  );
endinterface

// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiply, one MAC per cycle: C = A x B over 64x64 row-major RAMs.
module matmul_seq #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic         CLK,
  input  logic         RST_L,
  matmul_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic        first;
    logic        last;
    logic [11:0] ij;
  } tag_t;

  state_t        state, state_nxt;
  logic [5:0]    dim, i, j, k;
  logic          i_end, j_end, k_end, issue;
  logic          vld_d;
  tag_t          tag_d;
  logic [DW-1:0] acc, prod, acc_nxt;
  logic          c_we_q;
  logic [AW-1:0] c_addr_q;
  logic [DW-1:0] c_data_q;

  assign i_end = (i == dim);
  assign j_end = (j == dim);
  assign k_end = (k == dim);
  assign issue = (state == RUN);

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) state <= IDLE;
    else        state <= state_nxt;
  end

  // DRAIN ends once the final write is on the port and no read data is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (i_end && j_end && k_end) state_nxt = DRAIN;
      DRAIN:   if (c_we_q && !vld_d) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // k innermost, j middle, i outermost; all wrap together on the final issue.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      dim <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else if (state == IDLE && bus.start) begin
      dim <= bus.dim_m1;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else if (issue) begin
      if (k_end) begin
        k <= '0;
        if (j_end) begin
          j <= '0;
          i <= i_end ? 6'd0 : i + 6'd1;
        end else begin
          j <= j + 6'd1;
        end
      end else begin
        k <= k + 6'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      vld_d <= 1'b0;
      tag_d <= '0;
    end else begin
      vld_d <= issue;
      tag_d <= '{first: (k == 6'd0), last: k_end, ij: {i, j}};
    end
  end

  assign prod    = bus.a_data * bus.b_data;
  assign acc_nxt = tag_d.first ? prod : acc + prod;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      acc      <= '0;
      c_we_q   <= 1'b0;
      c_addr_q <= '0;
      c_data_q <= '0;
    end else begin
      c_we_q <= vld_d && tag_d.last;
      if (vld_d) acc <= acc_nxt;
      if (vld_d && tag_d.last) begin
        c_addr_q <= AW'(tag_d.ij);
        c_data_q <= acc_nxt;
      end
    end
  end

  assign bus.busy   = (state == RUN) || (state == DRAIN);
  assign bus.done   = (state == DONE);
  assign bus.rd_en  = issue;
  assign bus.a_addr = AW'({i, k});
  assign bus.b_addr = AW'({k, j});
  assign bus.c_we   = c_we_q;
  assign bus.c_addr = c_addr_q;
  assign bus.c_data = c_data_q;
endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 SHALL have parameter DW, default 32, meaning matrix element and accumulator width.
REQ-002 SHALL have parameter AW, default 12, meaning matrix RAM address width (64x64 elements, row-major, address = {row[5:0], col[5:0]}).
REQ-003 SHALL have port CLK  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_L  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a request to compute C = A x B; sampled only in IDLE.
REQ-006 SHALL have port dim_m1  input  6  meaning matrix dimension N minus 1 (N = 1..64); sampled only with an accepted start.
REQ-007 SHALL have port busy  output  1  meaning that a computation is in progress.
REQ-008 SHALL have port done  output  1  meaning a one-cycle completion pulse.
REQ-009 SHALL have port rd_en  output  1  meaning the read enable for the A and B RAMs.
REQ-010 SHALL have ports a_addr, b_addr  output  AW  meaning the read addresses for the A and B RAMs.
REQ-011 SHALL have ports a_data, b_data  input  DW  meaning RAM read data, valid exactly one cycle after the rd_en cycle.
REQ-012 SHALL have ports c_we  output  1, c_addr  output  AW, c_data  output  DW, meaning the C RAM write port.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 SHALL leave IDLE for RUN when start=1: latch dim_m1 and clear loop counters i, j, k to 0.
REQ-015 SHALL, in RUN, drive rd_en=1 every cycle with a_addr={i,k} and b_addr={k,j}; k is innermost, j middle, i outermost; each counter wraps to 0 after it reaches the latched dim_m1.
REQ-016 SHALL go from RUN to DRAIN after issuing i=j=k=dim_m1, for exactly N^3 issue cycles.
REQ-017 SHALL tag each issue with first (k=0), last (k=dim_m1) and {i,j}, and delay the tags one cycle to align them with the read data.
REQ-018 SHALL, in the data cycle, compute acc <= first ? a_data*b_data : acc + a_data*b_data, keeping the low DW bits (modulo 2^DW; no saturation, no overflow flag).
REQ-019 SHALL assert c_we one cycle after the data cycle of a last-tagged issue, with c_addr={i,j} and c_data=final acc. This is 2 cycles after the issue.
REQ-020 SHALL go from DRAIN to DONE in the cycle after the final c_we.
REQ-021 SHALL go from DONE to IDLE unconditionally after one cycle, with done=1 for that cycle only.
REQ-022 SHALL drive busy=1 in RUN and DRAIN and 0 otherwise.
REQ-023 SHALL produce this timing when start is sampled at edge 0: issue cycles 1..N^3, final c_we in cycle N^3+2, done in cycle N^3+3.
REQ-024 SHALL ignore start while busy or done is high, and SHALL not change the latched dimension mid-run.
REQ-025 SHALL, when start is held high continuously, accept a new run on the first IDLE cycle after DONE.
REQ-026 SHALL drive rd_en=0 and c_we=0 in IDLE and DONE; a_addr, b_addr, c_addr and c_data are don't-care when their enables are 0.

Reset
REQ-027 SHALL, on RST_L=0 and regardless of state, immediately force state=IDLE, i=j=k=0, acc=0, all pipeline tags invalid, busy=0, done=0, rd_en=0, c_we=0, a_addr=b_addr=c_addr=0 and c_data=0.
REQ-028 SHALL, after a mid-run reset, issue no further C writes and require a new start.

Verification
REQ-029 SHALL cover N=1: dim_m1=0, A[0]=3, B[0]=5, start at edge 0 -> rd_en in cycle 1, c_we in cycle 3 with c_addr=0x000 and c_data=15, done in cycle 4, busy high in cycles 1-3.
REQ-030 SHALL cover N=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> writes in order 0x000=19, 0x001=22, 0x040=43, 0x041=50, 8 issue cycles, done in cycle 11.
REQ-031 SHALL cover wrap: N=1, A=0xFFFFFFFF, B=2 -> c_data=0xFFFFFFFE.
REQ-032 SHALL cover start pulsed in cycle 5 of an N=2 run with dim_m1 changed to 63 -> no effect; the run completes exactly as in REQ-030.
REQ-033 SHALL cover RST_L low in cycle 4 of an N=2 run -> all outputs 0 in the same cycle, no subsequent c_we, and a new start completes correctly.
REQ-034 SHALL cover N=64: dim_m1=63 -> 262144 issue cycles, 4096 writes with the final c_addr=0xFFF, done in cycle 262147.
